// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: operation codes, flag bit positions
// and the top-level sequencing states.
package alu_pkg;

    typedef enum logic [3:0] {
        MODE_NOP  = 4'd0,
        MODE_MOV  = 4'd1,
        MODE_CMP  = 4'd2,
        MODE_TEST = 4'd3,
        MODE_SHL  = 4'd4,
        MODE_SHR  = 4'd5,
        MODE_ADD  = 4'd6,
        MODE_ADC  = 4'd7,
        MODE_SUB  = 4'd8,
        MODE_SBB  = 4'd9,
        MODE_MUL  = 4'd10,
        MODE_AND  = 4'd11,
        MODE_OR   = 4'd12,
        MODE_XOR  = 4'd13,
        MODE_NOT  = 4'd14,
        MODE_SAR  = 4'd15
    } alu_mode_e;

    localparam int FLAG_Z = 7;
    localparam int FLAG_S = 6;
    localparam int FLAG_C = 5;
    localparam int FLAG_V = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, WORD_SIZE iterations,
// done pulses for one cycle once the full 2*WORD_SIZE product is in product.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_SIZE-1:0]   a,
    input  logic [WORD_SIZE-1:0]   b,
    output logic                   done,
    output logic [2*WORD_SIZE-1:0] product
);

    localparam int CNT_W = $clog2(WORD_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_SIZE - 1);

    logic [2*WORD_SIZE-1:0] mcand_reg;
    logic [WORD_SIZE-1:0]   mplier_reg;
    logic [2*WORD_SIZE-1:0] prod_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   run_reg;
    logic                   done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{WORD_SIZE{1'b0}}, a};
            mplier_reg <= b;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b1;
            done_reg   <= 1'b0;
        end else if (run_reg) begin
            // Multiplicand walks left while the multiplier is consumed LSB first
            if (mplier_reg[0]) begin
                prod_reg <= prod_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_ITER) begin
                run_reg  <= 1'b0;
                done_reg <= 1'b1;
            end
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign done    = done_reg;
    assign product = prod_reg;

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready handshake, clocked flags
// (carry feeds ADC/SBB) and a multi-cycle multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int SHAMT_W   = $clog2(WORD_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           mode_select,
    input  logic [WORD_SIZE-1:0] input_A,
    input  logic [WORD_SIZE-1:0] input_B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] output_C,
    output logic [7:0]           flags,
    output logic                 busy
);

    localparam int MSB = WORD_SIZE - 1;
    localparam logic [WORD_SIZE-1:0] SHIFT_LIMIT = WORD_SIZE[WORD_SIZE-1:0];

    alu_state_e           state_reg, state_next;
    logic [WORD_SIZE-1:0] output_c_reg;
    logic [7:0]           flags_reg;
    logic                 out_valid_reg;

    alu_mode_e            mode;
    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic                 mul_finish;
    logic [2*WORD_SIZE-1:0] mul_product;
    logic [WORD_SIZE-1:0] prod_lo, prod_hi;
    logic [7:0]           mul_flags;

    logic                 cin_add, cin_sub;
    logic [WORD_SIZE:0]   sum_add, diff_sub;
    logic [SHAMT_W-1:0]   shamt;
    logic                 shift_big;
    logic [WORD_SIZE-1:0] shl_res, shr_res, sar_res;

    logic [WORD_SIZE-1:0] r_next;
    logic                 c_next, v_next;
    logic                 load_c, load_flags, set_valid;
    logic [7:0]           flags_next;

    assign mode      = alu_mode_e'(mode_select);
    assign in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (mode == MODE_MUL);

    alu_mul_seq #(.WORD_SIZE(WORD_SIZE)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (input_A),
        .b       (input_B),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_finish = (state_reg == MUL_BUSY) && mul_done;
    assign prod_lo    = mul_product[WORD_SIZE-1:0];
    assign prod_hi    = mul_product[2*WORD_SIZE-1:WORD_SIZE];
    assign mul_flags  = {(prod_lo == '0), prod_lo[MSB], |prod_hi, |prod_hi, 4'b0000};

    // Carry-in only participates for the with-carry variants
    assign cin_add  = (mode == MODE_ADC) && flags_reg[FLAG_C];
    assign cin_sub  = (mode == MODE_SBB) && flags_reg[FLAG_C];
    assign sum_add  = {1'b0, input_A} + {1'b0, input_B} + {{WORD_SIZE{1'b0}}, cin_add};
    assign diff_sub = {1'b0, input_A} - {1'b0, input_B} - {{WORD_SIZE{1'b0}}, cin_sub};

    // Out-of-range amounts are judged on the whole of input_B, not the truncated shamt
    assign shamt     = input_B[SHAMT_W-1:0];
    assign shift_big = (input_B >= SHIFT_LIMIT);
    assign shl_res   = shift_big ? '0 : (input_A << shamt);
    assign shr_res   = shift_big ? '0 : (input_A >> shamt);
    assign sar_res   = shift_big ? {WORD_SIZE{input_A[MSB]}}
                                 : WORD_SIZE'($signed(input_A) >>> shamt);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (mul_start) state_next = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        r_next     = '0;
        c_next     = 1'b0;
        v_next     = 1'b0;
        load_c     = 1'b0;
        load_flags = 1'b0;
        set_valid  = 1'b0;
        case (mode)
            MODE_NOP: ;
            MODE_MUL: ;
            MODE_MOV: begin
                r_next    = input_B;
                load_c    = 1'b1;
                set_valid = 1'b1;
            end
            MODE_ADD, MODE_ADC: begin
                r_next     = sum_add[MSB:0];
                c_next     = sum_add[WORD_SIZE];
                v_next     = (input_A[MSB] == input_B[MSB]) && (r_next[MSB] != input_A[MSB]);
                load_c     = 1'b1;
                load_flags = 1'b1;
                set_valid  = 1'b1;
            end
            MODE_SUB, MODE_SBB, MODE_CMP: begin
                r_next     = diff_sub[MSB:0];
                c_next     = diff_sub[WORD_SIZE];
                v_next     = (input_A[MSB] != input_B[MSB]) && (r_next[MSB] != input_A[MSB]);
                load_c     = (mode != MODE_CMP);
                load_flags = 1'b1;
                set_valid  = 1'b1;
            end
            MODE_TEST, MODE_AND: begin
                r_next     = input_A & input_B;
                load_c     = (mode == MODE_AND);
                load_flags = 1'b1;
                set_valid  = 1'b1;
            end
            MODE_OR, MODE_XOR, MODE_NOT, MODE_SHL, MODE_SHR, MODE_SAR: begin
                case (mode)
                    MODE_OR:  r_next = input_A | input_B;
                    MODE_XOR: r_next = input_A ^ input_B;
                    MODE_NOT: r_next = ~input_A;
                    MODE_SHL: r_next = shl_res;
                    MODE_SHR: r_next = shr_res;
                    default:  r_next = sar_res;
                endcase
                load_c     = 1'b1;
                load_flags = 1'b1;
                set_valid  = 1'b1;
            end
            default: ;
        endcase
        flags_next = {(r_next == '0), r_next[MSB], c_next, v_next, 4'b0000};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            output_c_reg  <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (mul_finish) begin
                output_c_reg <= prod_lo;
                flags_reg    <= mul_flags;
            end else if (accept) begin
                if (load_c)     output_c_reg <= r_next;
                if (load_flags) flags_reg    <= flags_next;
            end
            // A new result wins over the handoff of the old one in the same cycle
            if (mul_finish || (accept && set_valid)) begin
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign output_C  = output_c_reg;
    assign flags     = flags_reg;
    assign busy      = (state_reg == MUL_BUSY);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WORD_SIZE=8): a chained vector table for the
// single-cycle ops plus hand sequences for MUL latency, backpressure and reset.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] mode_select;
    logic [7:0] input_A, input_B;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] output_C;
    logic [7:0] flags;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WORD_SIZE(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode_select (mode_select),
        .input_A     (input_A),
        .input_B     (input_B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_C    (output_C),
        .flags       (flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_mode_e  mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_c;
        logic [7:0] exp_f;
        logic       exp_v;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Presents one operation and returns 1 time unit after the accepting edge
    task automatic apply(input alu_mode_e m, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        mode_select = m;
        input_A     = a;
        input_B     = b;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int bad;

        // Entries are chained: ADC/SBB rely on the carry left by the row before
        vecs[0]  = '{MODE_ADD,  8'h7F, 8'h01, 8'h80, 8'h50, 1'b1};
        vecs[1]  = '{MODE_ADD,  8'hFF, 8'h01, 8'h00, 8'hA0, 1'b1};
        vecs[2]  = '{MODE_ADC,  8'h00, 8'h00, 8'h01, 8'h00, 1'b1};
        vecs[3]  = '{MODE_SUB,  8'h10, 8'h20, 8'hF0, 8'h60, 1'b1};
        vecs[4]  = '{MODE_SBB,  8'h05, 8'h02, 8'h02, 8'h00, 1'b1};
        vecs[5]  = '{MODE_CMP,  8'h33, 8'h33, 8'h02, 8'h80, 1'b1};
        vecs[6]  = '{MODE_MOV,  8'h11, 8'h5A, 8'h5A, 8'h80, 1'b1};
        vecs[7]  = '{MODE_TEST, 8'hF0, 8'h0F, 8'h5A, 8'h80, 1'b1};
        vecs[8]  = '{MODE_SHL,  8'h81, 8'h01, 8'h02, 8'h00, 1'b1};
        vecs[9]  = '{MODE_SHR,  8'h81, 8'h04, 8'h08, 8'h00, 1'b1};
        vecs[10] = '{MODE_SAR,  8'h80, 8'h03, 8'hF0, 8'h40, 1'b1};
        vecs[11] = '{MODE_SAR,  8'h80, 8'h09, 8'hFF, 8'h40, 1'b1};
        vecs[12] = '{MODE_SHL,  8'h55, 8'h08, 8'h00, 8'h80, 1'b1};
        vecs[13] = '{MODE_AND,  8'hCC, 8'hAA, 8'h88, 8'h40, 1'b1};
        vecs[14] = '{MODE_OR,   8'h0C, 8'h30, 8'h3C, 8'h00, 1'b1};
        vecs[15] = '{MODE_XOR,  8'hFF, 8'hFF, 8'h00, 8'h80, 1'b1};
        vecs[16] = '{MODE_NOT,  8'h0F, 8'h00, 8'hF0, 8'h40, 1'b1};
        vecs[17] = '{MODE_SUB,  8'h80, 8'h01, 8'h7F, 8'h10, 1'b1};
        vecs[18] = '{MODE_ADD,  8'h80, 8'h80, 8'h00, 8'hB0, 1'b1};
        vecs[19] = '{MODE_SBB,  8'h00, 8'hFF, 8'h00, 8'hA0, 1'b1};
        vecs[20] = '{MODE_SHR,  8'h80, 8'h10, 8'h00, 8'h80, 1'b1};
        vecs[21] = '{MODE_NOP,  8'h12, 8'h34, 8'h00, 8'h80, 1'b0};

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        mode_select = 4'd0;
        input_A     = 8'h00;
        input_B     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_output_C", {24'd0, output_C}, 32'h00);
        check("rst_flags", {24'd0, flags}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i].mode, vecs[i].a, vecs[i].b);
            $display("vec %0d mode=%0d A=%02h B=%02h -> C=%02h flags=%02h valid=%0d",
                     i, vecs[i].mode, vecs[i].a, vecs[i].b, output_C, flags, out_valid);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_v});
            check($sformatf("vec%0d_C", i), {24'd0, output_C}, {24'd0, vecs[i].exp_c});
            check($sformatf("vec%0d_flags", i), {24'd0, flags}, {24'd0, vecs[i].exp_f});
        end

        // MUL: 0x10*0x10 = 0x0100 -> low 0x00, high nonzero
        apply(MODE_MUL, 8'h10, 8'h10);
        n   = 0;
        bad = 0;
        while (!out_valid && n < 40) begin
            if (!busy || in_ready) bad++;
            @(posedge clk);
            #1;
            n++;
        end
        $display("mul 10*10 latency=%0d C=%02h flags=%02h", n, output_C, flags);
        check("mul_latency", n, 32'd9);
        check("mul_busy_stall", bad, 32'd0);
        check("mul_C", {24'd0, output_C}, 32'h00);
        check("mul_flags", {24'd0, flags}, 32'hB0);
        check("mul_busy_done", {31'd0, busy}, 32'd0);

        // Backpressure: result must hold while out_ready is low
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        apply(MODE_ADD, 8'h01, 8'h02);
        mode_select = MODE_OR;
        input_A     = 8'h10;
        input_B     = 8'h01;
        in_valid    = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (in_ready || !out_valid || output_C !== 8'h03 || flags !== 8'h00) bad++;
        end
        $display("hold add 01+02 C=%02h flags=%02h stalls_bad=%0d", output_C, flags, bad);
        check("hold_stable", bad, 32'd0);
        out_ready = 1'b1;
        #1;
        check("hold_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("after release or 10|01 C=%02h flags=%02h", output_C, flags);
        check("release_valid", {31'd0, out_valid}, 32'd1);
        check("release_C", {24'd0, output_C}, 32'h11);
        check("release_flags", {24'd0, flags}, 32'h00);

        // Reset in the 4th MUL cycle aborts the multiply
        apply(MODE_MUL, 8'h03, 8'h05);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("reset mid-mul valid=%0d busy=%0d flags=%02h", out_valid, busy, flags);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_flags", {24'd0, flags}, 32'h00);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_stale", {31'd0, out_valid}, 32'd0);
        apply(MODE_ADD, 8'h01, 8'h01);
        $display("post-reset add 01+01 C=%02h flags=%02h", output_C, flags);
        check("post_valid", {31'd0, out_valid}, 32'd1);
        check("post_C", {24'd0, output_C}, 32'h02);
        check("post_flags", {24'd0, flags}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised successor of the combinational ALU, for the datapath execute stage. Operands enter and results leave through a valid/ready handshake. The flags register is explicit and clocked, so ADC/SBB read the carry from the previously completed operation. MUL is a multi-cycle shift-add, and SAR is a new mode.

Parameters:
WORD_SIZE, 8, operand/result width in bits (legal range 4..32)
SHAMT_W, $clog2(WORD_SIZE)+1, width of the effective shift amount taken from input_B

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operation presented
in_ready  output  1  block can accept operation this cycle
mode_select  input  4  operation code (see Behaviour)
input_A  input  WORD_SIZE  operand A
input_B  input  WORD_SIZE  operand B / shift amount
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
output_C  output  WORD_SIZE  registered result
flags  output  8  [7]Z [6]S [5]C [4]V, [3:0] always 0
busy  output  1  high while a MUL is iterating

Behaviour:
- Reset (takes priority over everything, including an in-flight MUL): output_C=0, flags=0, out_valid=0, busy=0, FSM=IDLE, multiplier state cleared.
- Accept is in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready); no combinational path from in_valid to in_ready.
- FSM states:
  - IDLE: on accept of a single-cycle op, go to IDLE with output_C, flags and out_valid=1 registered at that edge (latency 1). On accept of MUL, go to MUL_BUSY.
  - MUL_BUSY: runs WORD_SIZE iterations, then goes to IDLE with the result registered and out_valid=1. out_valid rises WORD_SIZE+1 cycles after accept (9 cycles for WORD_SIZE=8).
- out_valid stays high with output_C and flags stable until out_valid && out_ready. Result handoff and a new accept may occur in the same cycle (full throughput for single-cycle ops).
- NOP (0) is accepted but produces no result: out_valid is not set, flags and output_C are unchanged.
- Modes:
  - 1 MOV: C=B.
  - 2 CMP: flags as SUB, output_C unchanged.
  - 3 TEST: flags as AND, output_C unchanged.
  - 4 SHL, 5 SHR: logical shifts. 15 SAR: arithmetic shift right.
  - 6 ADD, 7 ADC, 8 SUB, 9 SBB, 10 MUL (low word).
  - 11 AND, 12 OR, 13 XOR.
  - 14 NOT: bitwise complement of A.
- Arithmetic uses WORD_SIZE+1-bit internal sums. cin is flags[C] at the accept cycle.
  - ADD/ADC: C = carry out of bit WORD_SIZE-1; V = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB/SBB/CMP: R = A-B-cin (cin=0 for SUB/CMP). C = borrow, i.e. A < B+cin evaluated at WORD_SIZE+1 bits. V = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- Z = (R==0), S = R[WORD_SIZE-1], for every mode that writes flags. MOV writes no flags.
- Logic ops, NOT and shifts: C=0, V=0, Z and S from the result.
- Shifts use B as amount. If B >= WORD_SIZE: SHL/SHR give 0; SAR gives all bits equal to A[msb].
- MUL: the full 2*WORD_SIZE product is formed. output_C = low word, Z from the low word, S = low[msb]. C = V = 1 if the high word is nonzero, else 0.
- CMP/TEST assert out_valid like any other op.
- Undefined behaviour is forbidden: every mode_select value is decoded.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic[3:0] alu_mode_e (the 16 modes);
  - flag index constants FLAG_Z=7, FLAG_S=6, FLAG_C=5, FLAG_V=4;
  - FSM typedef alu_state_e {IDLE, MUL_BUSY}.
- Sub-module alu_mul_seq: shift-add multiplier with start/done, WORD_SIZE-cycle iteration and a 2*WORD_SIZE product. The top-level FSM drives start and consumes done.

Test Plan:
- ADD A=0x7F, B=0x01 -> output_C=0x80, flags=0x50 (S,V), out_valid one cycle after accept.
- ADD 0xFF+0x01 -> 0x00, flags=0xA0 (Z,C); back-to-back ADC 0x00+0x00 -> 0x01, flags=0x00.
- SUB 0x10-0x20 -> 0xF0, flags=0x60 (S,C); then SBB 0x05-0x02 -> 0x02, flags=0x00; CMP 0x33,0x33 -> flags=0x80, output_C stays 0x02.
- MUL 0x10*0x10 -> out_valid exactly 9 cycles after accept; output_C=0x00, flags=0xB0 (Z,C,V); in_ready=0 and busy=1 throughout.
- SAR A=0x80, B=3 -> 0xF0; SAR B=9 -> 0xFF; SHL B=8 -> 0x00, Z set. Hold out_ready=0 for 3 cycles: output_C/flags stable, in_ready=0, and the next op is accepted in the cycle out_ready returns high.
- Reset asserted in the 4th MUL cycle -> next cycle out_valid=0, busy=0, flags=0, in_ready=1; a subsequent ADD 0x01+0x01 -> 0x02.
